ex_stage_unit: RTL and testbench

EX-stage consumer of the ID/EX pipeline register outputs. It selects operands, performs single-cycle ALU operations and a multi-cycle iterative MUL, and registers the results into the EX/MEM boundary. During a MUL it holds the pipeline with stall_o back to IF/ID and ID/EX, and emits bubbles downstream until the product is ready.

---
 rtl/ex_stage_unit_pkg.sv | 27 ++
 rtl/ex_stage_unit_mul_iter.sv | 76 +++++++
 rtl/ex_stage_unit.sv | 140 ++++++++++++++
 tb/tb_ex_stage_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_unit_pkg.sv
// Shared definitions for the EX stage: datapath widths, ALUOp and funct
// encodings, and the EX sequencing state type.
package ex_stage_unit_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // ALUOp encodings from the ID/EX control word. 2'b11 is reserved and
    // falls into the default (result 0) path.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type funct encodings (imm[5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/ex_stage_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier, lower DATA_W bits of a*b.
// Retires MUL_BITS_PER_CYCLE multiplier bits per busy cycle, so a product
// takes STEPS = DATA_W / MUL_BITS_PER_CYCLE cycles after start.
// MUL_BITS_PER_CYCLE must divide DATA_W.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset (abandons any product in flight)
//   start    load a/b, clear accumulator and counter, begin iterating
//   a, b     multiplicand / multiplier, sampled only on start
//   last     high during the final busy cycle (counter == STEPS-1)
//   product  accumulator; holds the full product once busy drops
module mul_iter
    import ex_stage_unit_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              last,
    output logic [DATA_W-1:0] product
);

    localparam int STEPS = DATA_W / MUL_BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] partial;

    // Partial product of the current multiplier chunk. Only the low
    // DATA_W bits matter, so signed and unsigned operands agree.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_BITS_PER_CYCLE;
            mplier <= mplier >> MUL_BITS_PER_CYCLE;
            if (cnt == LAST_CNT) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign last    = busy && (cnt == LAST_CNT);
    assign product = acc;

endmodule

// File: rtl/ex_stage_unit.sv
// ex_stage_unit: EX stage between ID/EX and EX/MEM. Operand select,
// single-cycle ALU, iterative MUL with pipeline stall, EX/MEM register.
// Ports:
//   clk_i, rst_i          clock / synchronous active-high reset
//   valid_i .. rd_addr_i  ID/EX register outputs (controls, operands, fields)
//   stall_o               combinational hold request to IF/ID and ID/EX
//   valid_o .. wr_addr_o  registered EX/MEM outputs
//
// state | meaning
// IDLE  | single-cycle ops pass through; a MUL starts the multiplier
// BUSY  | multiplier iterating, bubbles emitted, upstream held
// DONE  | product ready; capture MUL result with held ID/EX controls
module ex_stage_unit
    import ex_stage_unit_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        WB_i,
    input  logic [2:0]        M_i,
    input  logic              RegDst_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_W-1:0]  rt_addr_i,
    input  logic [REG_W-1:0]  rd_addr_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [1:0]        WB_o,
    output logic [2:0]        M_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic [REG_W-1:0]  wr_addr_o
);

    ex_state_t         state;
    logic [5:0]        funct;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  wr_addr;
    logic [DATA_W-1:0] alu_result;
    logic              is_mul;
    logic              mul_start;
    logic              mul_last;
    logic [DATA_W-1:0] mul_product;

    assign funct   = imm_i[5:0];
    assign op_b    = ALUSrc_i ? imm_i : rt_data_i;
    assign wr_addr = RegDst_i ? rd_addr_i : rt_addr_i;
    assign is_mul  = valid_i && (ALUOp_i == ALUOP_RTYPE) && (funct == FUNCT_MUL);

    // A MUL only starts from IDLE; DONE never looks at is_mul, so the held
    // instruction cannot retrigger itself.
    assign mul_start = (state == ST_IDLE) && is_mul;
    assign stall_o   = !rst_i && (mul_start || (state == ST_BUSY));

    always_comb begin
        alu_result = '0;
        case (ALUOp_i)
            ALUOP_ADD: alu_result = rs_data_i + op_b;
            ALUOP_SUB: alu_result = rs_data_i - op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_result = rs_data_i + op_b;
                    FUNCT_SUB: alu_result = rs_data_i - op_b;
                    FUNCT_AND: alu_result = rs_data_i & op_b;
                    FUNCT_OR:  alu_result = rs_data_i | op_b;
                    default:   alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    mul_iter #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_mul_iter (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (mul_start),
        .a       (rs_data_i),
        .b       (rt_data_i),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            valid_o      <= 1'b0;
            WB_o         <= '0;
            M_o          <= '0;
            result_o     <= '0;
            write_data_o <= '0;
            wr_addr_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mul) begin
                        valid_o <= 1'b0;
                        WB_o    <= '0;
                        M_o     <= '0;
                        state   <= ST_BUSY;
                    end else begin
                        // An empty slot still updates the data fields, but
                        // its controls are zeroed so nothing downstream acts.
                        valid_o      <= valid_i;
                        WB_o         <= valid_i ? WB_i : 2'b00;
                        M_o          <= valid_i ? M_i : 3'b000;
                        result_o     <= alu_result;
                        write_data_o <= rt_data_i;
                        wr_addr_o    <= wr_addr;
                    end
                end
                ST_BUSY: begin
                    valid_o <= 1'b0;
                    WB_o    <= '0;
                    M_o     <= '0;
                    if (mul_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_o      <= 1'b1;
                    WB_o         <= WB_i;
                    M_o          <= M_i;
                    result_o     <= mul_product;
                    write_data_o <= rt_data_i;
                    wr_addr_o    <= wr_addr;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
module tb_ex_stage_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_a, valid_b;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst, alusrc;
    logic [1:0]  aluop;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rta, rda;

    logic        stall_a, vo_a, stall_b, vo_b;
    logic [1:0]  wbo_a, wbo_b;
    logic [2:0]  mo_a, mo_b;
    logic [31:0] res_a, wd_a, res_b, wd_b;
    logic [4:0]  wa_a, wa_b;

    ex_stage_unit #(.MUL_BITS_PER_CYCLE(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .WB_i(wb), .M_i(m),
        .RegDst_i(regdst), .ALUOp_i(aluop), .ALUSrc_i(alusrc),
        .rs_data_i(rs), .rt_data_i(rt), .imm_i(imm),
        .rt_addr_i(rta), .rd_addr_i(rda),
        .stall_o(stall_a), .valid_o(vo_a), .WB_o(wbo_a), .M_o(mo_a),
        .result_o(res_a), .write_data_o(wd_a), .wr_addr_o(wa_a)
    );

    ex_stage_unit #(.MUL_BITS_PER_CYCLE(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .WB_i(wb), .M_i(m),
        .RegDst_i(regdst), .ALUOp_i(aluop), .ALUSrc_i(alusrc),
        .rs_data_i(rs), .rt_data_i(rt), .imm_i(imm),
        .rt_addr_i(rta), .rd_addr_i(rda),
        .stall_o(stall_b), .valid_o(vo_b), .WB_o(wbo_b), .M_o(mo_b),
        .result_o(res_b), .write_data_o(wd_b), .wr_addr_o(wa_b)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wa;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] wd;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic        stall;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] res;
        logic [4:0]  wa;
        logic [31:0] wd;
    } obs_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic obs_t get(input bit sel);
        obs_t o;
        if (sel) o = '{vo_b, stall_b, wbo_b, mo_b, res_b, wa_b, wd_b};
        else     o = '{vo_a, stall_a, wbo_a, mo_a, res_a, wa_a, wd_a};
        return o;
    endfunction

    // Reference ALU written from the instruction-set view.
    function automatic logic [31:0] model(input logic [1:0] op, input logic src,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] im);
        logic [31:0] y;
        y = src ? im : b;
        if (op == 2'b00) return a + y;
        if (op == 2'b01) return a - y;
        if (op == 2'b10) begin
            if (im[5:0] == 6'h20) return a + y;
            if (im[5:0] == 6'h22) return a - y;
            if (im[5:0] == 6'h24) return a & y;
            if (im[5:0] == 6'h25) return a | y;
            if (im[5:0] == 6'h18) return a * b;
        end
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic [1:0] op,
                         input logic src, input logic dst,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] ta, input logic [4:0] da,
                         input logic [1:0] w, input logic [2:0] mm);
        valid_a = va; valid_b = vb; aluop = op; alusrc = src; regdst = dst;
        rs = a; rt = b; imm = im; rta = ta; rda = da; wb = w; m = mm;
    endtask

    task automatic push_cur();
        exp_t e;
        e.res = model(aluop, alusrc, rs, rt, imm);
        e.wa  = regdst ? rda : rta;
        e.wb  = wb;
        e.m   = m;
        e.wd  = rt;
        sb.push_back(e);
    endtask

    task automatic expect_out(input string tag, input bit sel);
        obs_t o;
        exp_t e;
        o = get(sel);
        chk({tag, "_valid"}, 32'(o.v), 32'd1);
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, o.res, e.res);
            chk({tag, "_wr_addr"}, 32'(o.wa), 32'(e.wa));
            chk({tag, "_wb"}, 32'(o.wb), 32'(e.wb));
            chk({tag, "_m"}, 32'(o.m), 32'(e.m));
            chk({tag, "_wdata"}, o.wd, e.wd);
        end
    endtask

    task automatic expect_bubble(input string tag, input bit sel);
        obs_t o;
        o = get(sel);
        chk({tag, "_bub_valid"}, 32'(o.v), 32'd0);
        chk({tag, "_bub_ctl"}, {27'd0, o.wb, o.m}, 32'd0);
    endtask

    task automatic alu_op(input string tag, input logic [1:0] op, input logic src,
                          input logic dst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im);
        drive(1'b1, 1'b0, op, src, dst, a, b, im, 5'd3, 5'd12, 2'b01, 3'b101);
        push_cur();
        #1;
        chk({tag, "_stall"}, 32'(stall_a), 32'd0);
        tick();
        expect_out(tag, 1'b0);
    endtask

    task automatic run_mul(input string tag, input bit sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] da, input int exp_stalls);
        int n;
        obs_t o;
        drive(!sel, sel, 2'b10, 1'b0, 1'b1, a, b, 32'h0000_0018, 5'd1, da, 2'b11, 3'b010);
        push_cur();
        #1;
        n = 0;
        o = get(sel);
        while (o.stall && n < 200) begin
            n++;
            tick();
            expect_bubble(tag, sel);
            o = get(sel);
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
        tick();
        expect_out(tag, sel);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        logic [31:0] ra, rb;

        rst = 1'b1;
        drive(0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        o = get(1'b0);
        chk("reset_valid", 32'(o.v), 32'd0);
        chk("reset_stall", 32'(o.stall), 32'd0);
        chk("reset_result", o.res, 32'd0);
        chk("reset_misc", {20'd0, o.wb, o.m, o.wa}, 32'd0);
        chk("reset_wdata", o.wd, 32'd0);
        chk("reset_b_valid", 32'(vo_b), 32'd0);

        // addi 5 + (-3) into rt=9
        drive(1, 0, 2'b00, 1, 0, 32'd5, 32'h0000_0044, 32'hFFFF_FFFD, 5'd9, 5'd17, 2'b10, 3'b000);
        push_cur();
        tick();
        expect_out("addi", 1'b0);
        chk("addi_const", res_a, 32'd2);

        alu_op("and",     2'b10, 0, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0024);
        chk("and_const", res_a, 32'h00F0_00F0);
        alu_op("or",      2'b10, 0, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0025);
        chk("or_const", res_a, 32'hFFF0_FFF0);
        alu_op("sub_r",   2'b10, 0, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0022);
        chk("sub_const", res_a, 32'hE100_E100);
        alu_op("add_r",   2'b10, 0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0020);
        alu_op("unk",     2'b10, 0, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_002A);
        chk("unk_const", res_a, 32'd0);
        alu_op("subi",    2'b01, 1, 0, 32'd10, 32'd7, 32'd20);
        alu_op("rsvd",    2'b11, 0, 1, 32'd10, 32'd7, 32'd20);

        // MUL encoding with valid_i low: no stall, bubble out
        drive(0, 0, 2'b10, 0, 1, 32'd3, 32'd4, 32'h0000_0018, 5'd1, 5'd2, 2'b11, 3'b111);
        #1;
        chk("inv_mul_stall", 32'(stall_a), 32'd0);
        tick();
        expect_bubble("inv_mul", 1'b0);

        run_mul("mul7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33);
        chk("mul7_const", res_a, 32'hFFFF_FFEB);

        run_mul("mul4_big", 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd6, 9);
        run_mul("mul4_3x4", 1'b1, 32'd3, 32'd4, 5'd7, 9);
        run_mul("mul4_5x6", 1'b1, 32'd5, 32'd6, 5'd8, 9);
        chk("mul4_5x6_const", res_b, 32'd30);
        tick();
        expect_bubble("mul4_after", 1'b1);

        ra = $urandom;
        rb = $urandom;
        run_mul("mul4_rand", 1'b1, ra, rb, 5'd9, 9);
        run_mul("mul1_rand", 1'b0, rb, ra, 5'd10, 33);

        // Reset in the middle of a MUL: no result may ever appear for it
        drive(1, 0, 2'b10, 0, 1, 32'd9, 32'd9, 32'h0000_0018, 5'd1, 5'd11, 2'b11, 3'b010);
        #1;
        chk("rstmul_stall", 32'(stall_a), 32'd1);
        for (int i = 0; i < 11; i++) begin
            tick();
            expect_bubble("rstmul", 1'b0);
        end
        rst = 1'b1;
        drive(1, 0, 2'b00, 1, 0, 32'd100, 32'd0, 32'd23, 5'd4, 5'd0, 2'b10, 3'b001);
        tick();
        rst = 1'b0;
        o = get(1'b0);
        chk("rstmul_valid", 32'(o.v), 32'd0);
        chk("rstmul_result", o.res, 32'd0);
        chk("rstmul_misc", {20'd0, o.wb, o.m, o.wa}, 32'd0);
        #1;
        chk("rstmul_stall_after", 32'(stall_a), 32'd0);
        push_cur();
        tick();
        expect_out("post_rst_add", 1'b0);
        chk("post_rst_const", res_a, 32'd123);
        valid_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_quiet", 32'(vo_a), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
